control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multicycle microcode sequencer for the core. Holds the 5-bit state register (mcp_addr).
//  Decodes opcode, f3, mem_complete and the debug-module requests into the per-cycle
//  datapath enables and mux selects carried on the control-signal bundle.
//  Sits between the instruction register/decoder (upstream) and the datapath (downstream).
//  Also hosts the debug halted/resume/abstract-command states.
// PARAMETERS
//  RESET_HALTED   0  1: leave reset in HALTED instead of PROLOGUE
//  EBREAK_HALTS   1  1: SYSTEM f3=0 imm[0]=1 (ebreak) enters HALTED; 0: treated as nop
// PORTS
//  clk            in   1  core clock
//  rst            in   1  asynchronous active-high reset
//  opcode         in   5  instr[6:2] from IR
//  f3             in   3  instr[14:12] from IR
//  imm0           in   1  instr[20] (ebreak vs ecall)
//  mem_complete   in   1  memory access done this cycle
//  halt_req       in   1  debug halt request (level)
//  resume_req     in   1  debug resume request (level)
//  abs_valid      in   1  abstract command pending (level, held until abstract_done)
//  abs_op         in   5  abstract command code = CONTROL_SIGNALS__ABS_* state code
//  mcp_addr       out  5  current state
//  write_pc_ne/_ex/write_pc/write_ir/write_rd/write_csr  out 1 each  datapath write enables
//  mem_read, mem_write                                   out 1 each  bus strobes
//  addr_sel       out  1  0=ALU, 1=PC
//  rd_sel         out  2  00 ALU, 01 MEM, 10 CSR
//  alu_insel1     out  2  00 RS1, 01 PC, 10 zero
//  alu_insel2     out  2  00 RS2, 01 imm, 10 shamt
//  abstract_write, abstract_done, progbuf  out 1 each  debug handshake
//  halted         out  1  state==HALTED
// BEHAVIOUR
//  - Reset (async): mcp_addr=PROLOGUE (HALTED if RESET_HALTED); progbuf=0; all outputs 0 except
//    decoded from state. Outputs are combinational from mcp_addr and inputs.
//  - Unlisted outputs are 0 in every state. "Retire" = assert write_pc_ne (pc<=pc+4).
//    Next state after retire: HALTED if halt_req, else PROLOGUE.
//  - PROLOGUE: addr_sel=PC, mem_read=1. Hold until mem_complete; that cycle write_ir=1, next DISPATCH.
//  - DISPATCH: next = opcode if one of the 11 RV32I opcodes, else retire (illegal = nop).
//  - LUI/AUIPC/OPIMM/OP: write_rd, rd_sel=ALU. ALU1: ZR for LUI, PC for AUIPC, RS otherwise.
//    ALU2: IM, except OP=RS; OPIMM f3=001/101 uses IS. All retire.
//  - JAL/JALR: write_rd (link), write_pc_ex. ALU1=PC for JAL, RS for JALR; ALU2=IM.
//    No write_pc_ne; next per retire rule.
//  - BRANCH: ALU1=RS, ALU2=RS. Both write_pc_ex and write_pc_ne asserted; datapath takes ex when taken.
//  - LOAD: ALU1=RS, ALU2=IM, addr_sel=ALU, mem_read; ->LOAD_W. LOAD_W holds the same outputs
//    until mem_complete, then ->LOAD_1. LOAD_1: write_rd, rd_sel=MEM, retire.
//    mem_complete in LOAD also ->LOAD_1.
//  - STORE/STORE_W/STORE_1: same sequence with mem_write; STORE_1 retires only.
//  - MISCMEM: retire. SYSTEM f3!=0: write_rd, rd_sel=CSR, write_csr, retire.
//    SYSTEM f3=0: ebreak & (EBREAK_HALTS|progbuf) -> HALTED without retire; else retire.
//  - progbuf: set on ABS_EXEC, cleared on entry to HALTED. Entering HALTED with progbuf=1
//    pulses abstract_done.
//  - HALTED: no bus activity. Priority: abs_valid -> abs_op state (unknown code -> ABS_NA),
//    else resume_req -> RESUMING.
//  - RESUMING: 1 cycle, write_pc=0, next PROLOGUE (halt_req ignored for one instruction).
//  - ABS_REG: abstract_write=1, abstract_done=1 -> HALTED.
//  - ABS_NA: abstract_done=1 -> HALTED.
//  - ABS_EXEC: progbuf<=1 -> PROLOGUE.
//  - ABS_RMEM: addr_sel=ALU, ALU1=ZR, ALU2=IM, mem_read until mem_complete -> ABS_RMEM_1.
//    ABS_RMEM_1: abstract_write=1, abstract_done=1 -> HALTED.
//  - ABS_WMEM: same as ABS_RMEM with mem_write; ABS_WMEM_1: abstract_done=1 -> HALTED.
//  - halt_req mid-instruction is deferred to the retire point; never aborts a bus access.
//  - Async reset mid-access drops strobes immediately.
// TESTING
//  1. Reset, ADDI (opcode 00100, f3 000), mem_complete in cycle 2 -> PROLOGUE x2, DISPATCH, OPIMM
//     with write_rd=1, alu_insel2=01, write_pc_ne=1; 4 cycles total.
//  2. LW with mem_complete delayed 3 cycles -> LOAD_W held 3 cycles with mem_read=1, then LOAD_1
//     rd_sel=01 write_rd=1.
//  3. halt_req rises during STORE_W -> STORE_1 retires, next HALTED, halted=1, no mem strobes.
//  4. HALTED, abs_valid=1 abs_op=ABS_REG -> one cycle abstract_write=abstract_done=1, back in HALTED.
//  5. abs_op=ABS_EXEC; progbuf runs ADDI then EBREAK -> HALTED with abstract_done pulse;
//     progbuf=0 afterwards.
//  6. Unknown opcode 11111 -> DISPATCH then PROLOGUE with write_pc_ne=1; rst asserted in
//     LOAD_W -> mcp_addr=PROLOGUE immediately, mem_read=1 only from PROLOGUE decode.

Source files
------------

// File: rtl/control_sequencer.sv
// Multicycle microcode sequencer: 5-bit state register plus combinational decode of the
// per-cycle datapath enables, mux selects and debug-module handshake.
module control_sequencer #(
    parameter bit RESET_HALTED = 1'b0,
    parameter bit EBREAK_HALTS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] f3,
    input  logic       imm0,
    input  logic       mem_complete,
    input  logic       halt_req,
    input  logic       resume_req,
    input  logic       abs_valid,
    input  logic [4:0] abs_op,
    output logic [4:0] mcp_addr,
    output logic       write_pc_ne,
    output logic       write_pc_ex,
    output logic       write_pc,
    output logic       write_ir,
    output logic       write_rd,
    output logic       write_csr,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2,
    output logic       abstract_write,
    output logic       abstract_done,
    output logic       progbuf,
    output logic       halted
);

    // Instruction states share their code with the RV32I opcode so DISPATCH can jump directly.
    typedef enum logic [4:0] {
        S_LOAD       = 5'b00000,
        S_PROLOGUE   = 5'b00001,
        S_DISPATCH   = 5'b00010,
        S_MISCMEM    = 5'b00011,
        S_OPIMM      = 5'b00100,
        S_AUIPC      = 5'b00101,
        S_LOAD_W     = 5'b00110,
        S_LOAD_1     = 5'b00111,
        S_STORE      = 5'b01000,
        S_STORE_W    = 5'b01001,
        S_STORE_1    = 5'b01010,
        S_OP         = 5'b01100,
        S_LUI        = 5'b01101,
        S_HALTED     = 5'b10000,
        S_RESUMING   = 5'b10001,
        S_ABS_REG    = 5'b10010,
        S_ABS_NA     = 5'b10011,
        S_ABS_EXEC   = 5'b10100,
        S_ABS_RMEM   = 5'b10101,
        S_ABS_RMEM_1 = 5'b10110,
        S_ABS_WMEM   = 5'b10111,
        S_BRANCH     = 5'b11000,
        S_JALR       = 5'b11001,
        S_ABS_WMEM_1 = 5'b11010,
        S_JAL        = 5'b11011,
        S_SYSTEM     = 5'b11100
    } state_t;

    localparam logic [1:0] RD_ALU = 2'b00, RD_MEM = 2'b01, RD_CSR = 2'b10;
    localparam logic [1:0] A1_RS  = 2'b00, A1_PC  = 2'b01, A1_ZR  = 2'b10;
    localparam logic [1:0] A2_RS  = 2'b00, A2_IM  = 2'b01, A2_IS  = 2'b10;

    state_t state, state_nx;
    state_t retire_nx;
    logic   retire;
    logic   progbuf_q;
    logic   resume_skip;

    assign mcp_addr = state;
    assign progbuf  = progbuf_q;
    assign halted   = (state == S_HALTED);

    // The first instruction after a resume always completes, even with halt_req held.
    assign retire_nx = (halt_req && !resume_skip) ? S_HALTED : S_PROLOGUE;

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no path infers a latch.
        state_nx       = state;
        retire         = 1'b0;
        write_pc_ne    = 1'b0;
        write_pc_ex    = 1'b0;
        write_pc       = 1'b0;
        write_ir       = 1'b0;
        write_rd       = 1'b0;
        write_csr      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr_sel       = 1'b0;
        rd_sel         = RD_ALU;
        alu_insel1     = A1_RS;
        alu_insel2     = A2_RS;
        abstract_write = 1'b0;
        abstract_done  = 1'b0;

        unique case (state)
            S_PROLOGUE: begin
                addr_sel = 1'b1;
                mem_read = 1'b1;
                if (mem_complete) begin
                    write_ir = 1'b1;
                    state_nx = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                case (opcode)
                    S_LOAD, S_MISCMEM, S_OPIMM, S_AUIPC, S_STORE, S_OP,
                    S_LUI, S_BRANCH, S_JALR, S_JAL, S_SYSTEM:
                        state_nx = state_t'(opcode);
                    default: begin
                        write_pc_ne = 1'b1;
                        retire      = 1'b1;
                        state_nx    = retire_nx;
                    end
                endcase
            end
            S_LUI, S_AUIPC, S_OPIMM, S_OP: begin
                write_rd    = 1'b1;
                write_pc_ne = 1'b1;
                retire      = 1'b1;
                state_nx    = retire_nx;
                if (state == S_LUI)        alu_insel1 = A1_ZR;
                else if (state == S_AUIPC) alu_insel1 = A1_PC;
                if (state == S_OP)                              alu_insel2 = A2_RS;
                else if (state == S_OPIMM && f3[1:0] == 2'b01)  alu_insel2 = A2_IS;
                else                                            alu_insel2 = A2_IM;
            end
            S_JAL, S_JALR: begin
                write_rd    = 1'b1;
                write_pc_ex = 1'b1;
                alu_insel1  = (state == S_JAL) ? A1_PC : A1_RS;
                alu_insel2  = A2_IM;
                retire      = 1'b1;
                state_nx    = retire_nx;
            end
            S_BRANCH: begin
                write_pc_ex = 1'b1;
                write_pc_ne = 1'b1;
                retire      = 1'b1;
                state_nx    = retire_nx;
            end
            S_LOAD, S_LOAD_W, S_STORE, S_STORE_W: begin
                alu_insel2 = A2_IM;
                mem_read   = (state == S_LOAD)  || (state == S_LOAD_W);
                mem_write  = (state == S_STORE) || (state == S_STORE_W);
                if (mem_complete)
                    state_nx = mem_read ? S_LOAD_1 : S_STORE_1;
                else
                    state_nx = mem_read ? S_LOAD_W : S_STORE_W;
            end
            S_LOAD_1, S_STORE_1, S_MISCMEM: begin
                write_rd    = (state == S_LOAD_1);
                rd_sel      = (state == S_LOAD_1) ? RD_MEM : RD_ALU;
                write_pc_ne = 1'b1;
                retire      = 1'b1;
                state_nx    = retire_nx;
            end
            S_SYSTEM: begin
                if (f3 != 3'b000) begin
                    write_rd    = 1'b1;
                    rd_sel      = RD_CSR;
                    write_csr   = 1'b1;
                    write_pc_ne = 1'b1;
                    retire      = 1'b1;
                    state_nx    = retire_nx;
                end else if (imm0 && (EBREAK_HALTS || progbuf_q)) begin
                    state_nx = S_HALTED;
                end else begin
                    write_pc_ne = 1'b1;
                    retire      = 1'b1;
                    state_nx    = retire_nx;
                end
            end
            S_HALTED: begin
                if (abs_valid) begin
                    case (abs_op)
                        S_ABS_REG, S_ABS_NA, S_ABS_EXEC, S_ABS_RMEM, S_ABS_WMEM:
                            state_nx = state_t'(abs_op);
                        default: state_nx = S_ABS_NA;
                    endcase
                end else if (resume_req) begin
                    state_nx = S_RESUMING;
                end
            end
            S_RESUMING: state_nx = S_PROLOGUE;
            S_ABS_REG: begin
                abstract_write = 1'b1;
                abstract_done  = 1'b1;
                state_nx       = S_HALTED;
            end
            S_ABS_NA: begin
                abstract_done = 1'b1;
                state_nx      = S_HALTED;
            end
            S_ABS_EXEC: state_nx = S_PROLOGUE;
            S_ABS_RMEM, S_ABS_WMEM: begin
                alu_insel1 = A1_ZR;
                alu_insel2 = A2_IM;
                mem_read   = (state == S_ABS_RMEM);
                mem_write  = (state == S_ABS_WMEM);
                if (mem_complete)
                    state_nx = (state == S_ABS_RMEM) ? S_ABS_RMEM_1 : S_ABS_WMEM_1;
            end
            S_ABS_RMEM_1: begin
                abstract_write = 1'b1;
                abstract_done  = 1'b1;
                state_nx       = S_HALTED;
            end
            S_ABS_WMEM_1: begin
                abstract_done = 1'b1;
                state_nx      = S_HALTED;
            end
            default: state_nx = S_PROLOGUE;
        endcase

        // Program-buffer completion is reported on the cycle that re-enters HALTED.
        if (progbuf_q && state != S_HALTED && state_nx == S_HALTED)
            abstract_done = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_HALTED ? S_HALTED : S_PROLOGUE;
            progbuf_q   <= 1'b0;
            resume_skip <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nx;
            if (state == S_ABS_EXEC)
                progbuf_q <= 1'b1;
            else if (state != S_HALTED && state_nx == S_HALTED)
                progbuf_q <= 1'b0;
            if (state == S_RESUMING)
                resume_skip <= 1'b1;
            else if (retire || state_nx == S_HALTED)
                resume_skip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/execute, loads, stores, debug halt,
// abstract commands, program buffer, illegal opcode and async reset with hand-derived outputs.
module tb_control_sequencer;

    localparam logic [4:0] LOAD = 5'd0, PRO = 5'd1, DIS = 5'd2, OPIMM = 5'd4;
    localparam logic [4:0] LOAD_W = 5'd6, LOAD_1 = 5'd7, STORE = 5'd8, STORE_W = 5'd9;
    localparam logic [4:0] STORE_1 = 5'd10, SYSTEM = 5'd28, HALTED = 5'd16, RESUMING = 5'd17;
    localparam logic [4:0] ABS_REG = 5'd18, ABS_NA = 5'd19, ABS_EXEC = 5'd20;
    localparam logic [4:0] ABS_RMEM = 5'd21, ABS_RMEM_1 = 5'd22;

    typedef struct packed {
        logic       wpc_ne, wpc_ex, wpc, wir, wrd, wcsr, mrd, mwr, asel;
        logic [1:0] rsel, a1, a2;
        logic       aw, ad, pb, hlt;
    } ctl_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] opcode, abs_op, mcp_addr;
    logic [2:0] f3;
    logic imm0, mem_complete, halt_req, resume_req, abs_valid;
    logic write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr;
    logic mem_read, mem_write, addr_sel, abstract_write, abstract_done, progbuf, halted;
    logic [1:0] rd_sel, alu_insel1, alu_insel2;
    ctl_t act, e;
    int n_checks = 0;
    int n_errors = 0;

    control_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .imm0(imm0),
        .mem_complete(mem_complete), .halt_req(halt_req), .resume_req(resume_req),
        .abs_valid(abs_valid), .abs_op(abs_op), .mcp_addr(mcp_addr),
        .write_pc_ne(write_pc_ne), .write_pc_ex(write_pc_ex), .write_pc(write_pc),
        .write_ir(write_ir), .write_rd(write_rd), .write_csr(write_csr),
        .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel), .rd_sel(rd_sel),
        .alu_insel1(alu_insel1), .alu_insel2(alu_insel2), .abstract_write(abstract_write),
        .abstract_done(abstract_done), .progbuf(progbuf), .halted(halted)
    );

    always #5 clk = ~clk;

    assign act = '{wpc_ne: write_pc_ne, wpc_ex: write_pc_ex, wpc: write_pc, wir: write_ir,
                   wrd: write_rd, wcsr: write_csr, mrd: mem_read, mwr: mem_write,
                   asel: addr_sel, rsel: rd_sel, a1: alu_insel1, a2: alu_insel2,
                   aw: abstract_write, ad: abstract_done, pb: progbuf, hlt: halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Settle after input changes, then compare state code and the whole control bundle.
    task automatic cyc(input string tag, input logic [4:0] st, input ctl_t ex);
        #1;
        check({tag, "_state"}, {27'd0, mcp_addr}, {27'd0, st});
        check({tag, "_ctl"}, {12'd0, act}, {12'd0, ex});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch cycle with mem_complete, loading the next instruction into the IR inputs.
    task automatic fetch(input string tag, input logic [4:0] op, input logic [2:0] fn,
                         input logic i0, input logic pb);
        ctl_t x;
        mem_complete = 1'b1; opcode = op; f3 = fn; imm0 = i0;
        x = '0; x.mrd = 1'b1; x.asel = 1'b1; x.wir = 1'b1; x.pb = pb;
        cyc(tag, PRO, x);
        tick();
        mem_complete = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; opcode = '0; f3 = '0; imm0 = 1'b0; mem_complete = 1'b0;
        halt_req = 1'b0; resume_req = 1'b0; abs_valid = 1'b0; abs_op = '0;
        e = '0; e.mrd = 1'b1; e.asel = 1'b1;
        cyc("reset", PRO, e);
        #11 rst = 1'b0;

        // ADDI with fetch completing in the second cycle
        e = '0; e.mrd = 1'b1; e.asel = 1'b1;
        cyc("t1_fetch0", PRO, e); tick();
        fetch("t1_fetch1", 5'b00100, 3'b000, 1'b0, 1'b0);
        e = '0; cyc("t1_disp", DIS, e); tick();
        e = '0; e.wrd = 1'b1; e.a2 = 2'b01; e.wpc_ne = 1'b1;
        cyc("t1_opimm", OPIMM, e); tick();

        // LW with memory completing on the third LOAD_W cycle
        fetch("t2_fetch", 5'b00000, 3'b010, 1'b0, 1'b0);
        e = '0; cyc("t2_disp", DIS, e); tick();
        e = '0; e.mrd = 1'b1; e.a2 = 2'b01;
        cyc("t2_load", LOAD, e); tick();
        cyc("t2_wait0", LOAD_W, e); tick();
        cyc("t2_wait1", LOAD_W, e); tick();
        mem_complete = 1'b1;
        cyc("t2_wait2", LOAD_W, e); tick();
        mem_complete = 1'b0;
        e = '0; e.wrd = 1'b1; e.rsel = 2'b01; e.wpc_ne = 1'b1;
        cyc("t2_load1", LOAD_1, e); tick();

        // SW with halt_req arriving during STORE_W
        fetch("t3_fetch", 5'b01000, 3'b010, 1'b0, 1'b0);
        e = '0; cyc("t3_disp", DIS, e); tick();
        e = '0; e.mwr = 1'b1; e.a2 = 2'b01;
        cyc("t3_store", STORE, e); tick();
        halt_req = 1'b1;
        cyc("t3_wait0", STORE_W, e); tick();
        mem_complete = 1'b1;
        cyc("t3_wait1", STORE_W, e); tick();
        mem_complete = 1'b0;
        e = '0; e.wpc_ne = 1'b1;
        cyc("t3_store1", STORE_1, e); tick();
        e = '0; e.hlt = 1'b1;
        cyc("t3_halted", HALTED, e); tick();
        halt_req = 1'b0;
        cyc("t3_halted_hold", HALTED, e); tick();

        // Abstract register access
        abs_valid = 1'b1; abs_op = ABS_REG;
        cyc("t4_halted", HALTED, e); tick();
        abs_valid = 1'b0;
        e = '0; e.aw = 1'b1; e.ad = 1'b1;
        cyc("t4_absreg", ABS_REG, e); tick();
        e = '0; e.hlt = 1'b1;
        cyc("t4_back", HALTED, e);

        // Unknown abstract code falls to ABS_NA
        abs_valid = 1'b1; abs_op = 5'd0; tick();
        abs_valid = 1'b0;
        e = '0; e.ad = 1'b1;
        cyc("t4_absna", ABS_NA, e); tick();

        // Abstract memory read with one wait cycle
        abs_valid = 1'b1; abs_op = ABS_RMEM; tick();
        abs_valid = 1'b0;
        e = '0; e.mrd = 1'b1; e.a1 = 2'b10; e.a2 = 2'b01;
        cyc("t4_rmem0", ABS_RMEM, e); tick();
        mem_complete = 1'b1;
        cyc("t4_rmem1", ABS_RMEM, e); tick();
        mem_complete = 1'b0;
        e = '0; e.aw = 1'b1; e.ad = 1'b1;
        cyc("t4_rmem_done", ABS_RMEM_1, e); tick();

        // Program buffer: ADDI then EBREAK
        abs_valid = 1'b1; abs_op = ABS_EXEC;
        e = '0; e.hlt = 1'b1;
        cyc("t5_halted", HALTED, e); tick();
        abs_valid = 1'b0;
        e = '0; cyc("t5_exec", ABS_EXEC, e); tick();
        fetch("t5_fetch_addi", 5'b00100, 3'b000, 1'b0, 1'b1);
        e = '0; e.pb = 1'b1; cyc("t5_disp_addi", DIS, e); tick();
        e.wrd = 1'b1; e.a2 = 2'b01; e.wpc_ne = 1'b1;
        cyc("t5_addi", OPIMM, e); tick();
        fetch("t5_fetch_ebreak", 5'b11100, 3'b000, 1'b1, 1'b1);
        e = '0; e.pb = 1'b1; cyc("t5_disp_ebreak", DIS, e); tick();
        e.ad = 1'b1;
        cyc("t5_ebreak", SYSTEM, e); tick();
        e = '0; e.hlt = 1'b1;
        cyc("t5_halted_pb0", HALTED, e);

        // Resume with halt_req held: first instruction still retires to PROLOGUE
        resume_req = 1'b1; tick();
        resume_req = 1'b0; halt_req = 1'b1;
        e = '0; cyc("t6_resuming", RESUMING, e); tick();
        fetch("t6_fetch_addi", 5'b00100, 3'b000, 1'b0, 1'b0);
        e = '0; cyc("t6_disp_addi", DIS, e); tick();
        e.wrd = 1'b1; e.a2 = 2'b01; e.wpc_ne = 1'b1;
        cyc("t6_addi_skip_halt", OPIMM, e); tick();
        halt_req = 1'b0;

        // Illegal opcode retires as a nop straight from DISPATCH
        fetch("t6_fetch_bad", 5'b11111, 3'b000, 1'b0, 1'b0);
        e = '0; e.wpc_ne = 1'b1;
        cyc("t6_disp_bad", DIS, e); tick();

        // Async reset during LOAD_W
        fetch("t6_fetch_lw", 5'b00000, 3'b010, 1'b0, 1'b0);
        tick(); tick();
        e = '0; e.mrd = 1'b1; e.a2 = 2'b01;
        cyc("t6_loadw", LOAD_W, e);
        #1 rst = 1'b1;
        e = '0; e.mrd = 1'b1; e.asel = 1'b1;
        cyc("t6_rst_mid", PRO, e);
        #2 rst = 1'b0;
        tick();
        cyc("t6_after_rst", PRO, e);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
